// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and default geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 10;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker. Holds the port granted last; on a tie the
// other port wins. The pointer resets to B so that A wins the first tie.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    input  logic upd_port,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_q;
    logic last_d;

    // Combinational pick: single requester wins, tie goes to the port not granted last.
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_port  = PORT_A;
        if (req_a && req_b) begin
            gnt_port = (last_q == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            gnt_port = PORT_B;
        end
    end

    // Pointer moves to the winner when its transaction completes.
    always_comb begin
        last_d = last_q;
        if (upd) begin
            last_d = upd_port;
        end
    end

    // Pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// One access per three cycles: grant in IDLE, strobe in ACCESS, ack in RESP.
// Optional address range check enabled by defining DMEM_ARB_RANGE_CHECK_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a request; pick winner and latch its fields
// ST_ACCESS | drive one-cycle mem_write / mem_read from the latched fields
// ST_RESP   | capture read data, pulse the winner's ack, move the pointer
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_daddress,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              gnt_valid;
    logic              gnt_port;
    logic              upd;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;

    rr_arb2 u_rr_arb2 (
        .clock     (clock),
        .reset     (reset),
        .req_a     (a_req),
        .req_b     (b_req),
        .upd       (upd),
        .upd_port  (win_q),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Mux the candidate winner's request fields and range-check its address.
    always_comb begin
        sel_we    = (gnt_port == PORT_B) ? b_we    : a_we;
        sel_addr  = (gnt_port == PORT_B) ? b_addr  : a_addr;
        sel_wdata = (gnt_port == PORT_B) ? b_wdata : a_wdata;
        sel_bad   = CHECK_EN && (sel_addr >= DEPTH_A);
    end

    // Next-state, latch and strobe/ack generation.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        upd       = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        a_err     = 1'b0;
        b_err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    win_d   = gnt_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_bad;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An out-of-range access keeps the memory untouched.
                mem_write = we_q && !err_q;
                mem_read  = !we_q && !err_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (win_q == PORT_A) begin
                    a_ack = 1'b1;
                    a_err = err_q;
                    if (!we_q && !err_q) begin
                        a_rdata_d = mem_dout;
                    end
                end else begin
                    b_ack = 1'b1;
                    b_err = err_q;
                    if (!we_q && !err_q) begin
                        b_rdata_d = mem_dout;
                    end
                end
                upd     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is presented in the ack cycle straight from memory and held afterwards.
    assign a_rdata      = a_rdata_d;
    assign b_rdata      = b_rdata_d;
    assign mem_daddress = addr_q;
    assign mem_din      = wdata_q;

    // State and latch registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level schedule model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    localparam int NT = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ack, a_err;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ack, b_err;
    logic [31:0] b_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_daddress, mem_din;
    logic [31:0] mem_dout = '0;

    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [31:0] ref_mem [0:15] = '{default: 32'h0};
    logic [31:0] ref_rd [2];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    // Random-run data: per-port requests and the model's expected schedule.
    bit          r_we    [2][NT];
    logic [3:0]  r_addr  [2][NT];
    logic [31:0] r_wdata [2][NT];
    int          r_gap   [2][NT];
    int          s_port  [2*NT];
    int          s_g     [2*NT];
    bit          s_we    [2*NT];
    bit          s_err   [2*NT];
    logic [3:0]  s_addr  [2*NT];
    logic [31:0] s_wdata [2*NT];
    logic [31:0] s_rdata [2*NT];
    int          nsched, t0, tend;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_daddress(mem_daddress), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory with registered read data.
    always @(posedge clock) begin
        if (mem_write) mem[mem_daddress[3:0]] <= mem_din;
        if (mem_read)  mem_dout <= mem[mem_daddress[3:0]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        a_req = 0; b_req = 0; reset = 1;
        @(negedge clock);
        reset = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;
    endtask

    task automatic test_reset();
        a_req = 1; b_req = 1; reset = 1;
        repeat (3) @(negedge clock);
        nvec++; if (a_ack !== 1'b0) begin nerr++; $display("FAIL rst_a_ack got %b exp 0", a_ack); end
        nvec++; if (b_ack !== 1'b0) begin nerr++; $display("FAIL rst_b_ack got %b exp 0", b_ack); end
        nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL rst_a_err got %b exp 0", a_err); end
        nvec++; if (b_err !== 1'b0) begin nerr++; $display("FAIL rst_b_err got %b exp 0", b_err); end
        nvec++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
        nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
        nvec++; if (a_rdata !== 32'h0) begin nerr++; $display("FAIL rst_a_rdata got %h exp 0", a_rdata); end
        nvec++; if (b_rdata !== 32'h0) begin nerr++; $display("FAIL rst_b_rdata got %h exp 0", b_rdata); end
        nvec++; if (mem_daddress !== 32'h0) begin nerr++; $display("FAIL rst_mem_daddress got %h exp 0", mem_daddress); end
        nvec++; if (mem_din !== 32'h0) begin nerr++; $display("FAIL rst_mem_din got %h exp 0", mem_din); end
        a_req = 0; b_req = 0; reset = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(negedge clock);
    endtask

    task automatic test_single_a();
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 32'hDEADBEEF;
        @(negedge clock);
        nvec++; if (mem_write !== 1'b1) begin nerr++; $display("FAIL wr_strobe got %b exp 1", mem_write); end
        nvec++; if (mem_daddress !== 32'd3) begin nerr++; $display("FAIL wr_addr got %h exp 3", mem_daddress); end
        nvec++; if (mem_din !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_din got %h exp deadbeef", mem_din); end
        nvec++; if (a_ack !== 1'b0) begin nerr++; $display("FAIL wr_early_ack got %b exp 0", a_ack); end
        @(negedge clock);
        nvec++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL wr_strobe_len got %b exp 0", mem_write); end
        nvec++; if (a_ack !== 1'b1) begin nerr++; $display("FAIL wr_ack got %b exp 1", a_ack); end
        nvec++; if (b_ack !== 1'b0) begin nerr++; $display("FAIL wr_b_ack got %b exp 0", b_ack); end
        ref_mem[3] = 32'hDEADBEEF;
        a_req = 0;
        @(negedge clock);
        nvec++; if (a_ack !== 1'b0) begin nerr++; $display("FAIL wr_ack_len got %b exp 0", a_ack); end
        a_req = 1; a_we = 0; a_addr = 3;
        @(negedge clock);
        nvec++; if (mem_read !== 1'b1) begin nerr++; $display("FAIL rd_strobe got %b exp 1", mem_read); end
        nvec++; if (mem_daddress !== 32'd3) begin nerr++; $display("FAIL rd_addr got %h exp 3", mem_daddress); end
        @(negedge clock);
        nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL rd_strobe_len got %b exp 0", mem_read); end
        nvec++; if (a_ack !== 1'b1) begin nerr++; $display("FAIL rd_ack got %b exp 1", a_ack); end
        nvec++; if (a_rdata !== ref_mem[3]) begin nerr++; $display("FAIL rd_data got %h exp %h", a_rdata, ref_mem[3]); end
        ref_rd[0] = ref_mem[3];
        a_req = 0;
        @(negedge clock);
        nvec++; if (a_rdata !== ref_rd[0]) begin nerr++; $display("FAIL rd_hold got %h exp %h", a_rdata, ref_rd[0]); end
    endtask

    task automatic test_tie();
        int ka, kb;
        logic [31:0] wd;
        ka = -1; kb = -1; wd = $urandom;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 1;
        b_req = 1; b_we = 1; b_addr = 2; b_wdata = wd;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            nvec++; if (a_ack && b_ack) begin nerr++; $display("FAIL tie_overlap got both acks at +%0d exp one", k); end
            if (a_ack) begin
                ka = k; a_req = 0;
                nvec++; if (a_rdata !== ref_mem[1]) begin nerr++; $display("FAIL tie_a_rdata got %h exp %h", a_rdata, ref_mem[1]); end
                ref_rd[0] = ref_mem[1];
            end
            if (b_ack) begin kb = k; b_req = 0; end
        end
        ref_mem[2] = wd;
        nvec++; if (ka !== 2) begin nerr++; $display("FAIL tie_a_cycle got %0d exp 2", ka); end
        nvec++; if (kb !== 5) begin nerr++; $display("FAIL tie_b_cycle got %0d exp 5", kb); end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 2;
        b_req = 1; b_we = 0; b_addr = 3;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            if (a_ack || b_ack) begin
                nvec++; if (k !== 2 + 3 * n) begin nerr++; $display("FAIL b2b_cycle ack %0d got +%0d exp +%0d", n, k, 2 + 3 * n); end
                nvec++; if (b_ack !== n[0]) begin nerr++; $display("FAIL b2b_order ack %0d got port %0d exp %0d", n, b_ack, n[0]); end
                nvec++; if (a_ack && b_ack) begin nerr++; $display("FAIL b2b_overlap got both acks exp one"); end
                if (a_ack) begin
                    nvec++; if (a_rdata !== ref_mem[2]) begin nerr++; $display("FAIL b2b_a_rdata got %h exp %h", a_rdata, ref_mem[2]); end
                    ref_rd[0] = ref_mem[2];
                end
                if (b_ack) begin
                    nvec++; if (b_rdata !== ref_mem[3]) begin nerr++; $display("FAIL b2b_b_rdata got %h exp %h", b_rdata, ref_mem[3]); end
                    ref_rd[1] = ref_mem[3];
                end
                n++;
                if (n == 6) begin a_req = 0; b_req = 0; end
            end
        end
        nvec++; if (n !== 6) begin nerr++; $display("FAIL b2b_count got %0d exp 6", n); end
    endtask

    task automatic test_addr_change();
        logic [31:0] wd;
        wd = $urandom;
        b_req = 1; b_we = 1; b_addr = 4; b_wdata = wd;
        @(negedge clock);
        b_addr = 7;
        #1;
        nvec++; if (mem_write !== 1'b1) begin nerr++; $display("FAIL chg_strobe got %b exp 1", mem_write); end
        nvec++; if (mem_daddress !== 32'd4) begin nerr++; $display("FAIL chg_addr got %h exp 4", mem_daddress); end
        @(negedge clock);
        nvec++; if (b_ack !== 1'b1) begin nerr++; $display("FAIL chg_ack got %b exp 1", b_ack); end
        b_req = 0;
        ref_mem[4] = wd;
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 4;
        repeat (2) @(negedge clock);
        nvec++; if (a_rdata !== wd) begin nerr++; $display("FAIL chg_readback got %h exp %h", a_rdata, wd); end
        ref_rd[0] = wd;
        a_req = 0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int ka, kb;
        ka = -1; kb = -1;
        a_req = 1; a_we = 0; a_addr = 5;
        repeat (2) @(negedge clock);
        a_req = 0;
        @(negedge clock);
        a_req = 1; a_addr = 6;
        @(negedge clock);
        nvec++; if (mem_read !== 1'b1) begin nerr++; $display("FAIL rmid_strobe got %b exp 1", mem_read); end
        reset = 1;
        @(negedge clock);
        nvec++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL rmid_strobe_drop got %b exp 0", mem_read); end
        nvec++; if (a_ack !== 1'b0) begin nerr++; $display("FAIL rmid_no_ack got %b exp 0", a_ack); end
        reset = 0; a_req = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(negedge clock);
        a_req = 1; a_addr = 5;
        b_req = 1; b_we = 0; b_addr = 6;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (a_ack) begin ka = k; a_req = 0; ref_rd[0] = ref_mem[5]; end
            if (b_ack) begin kb = k; b_req = 0; ref_rd[1] = ref_mem[6]; end
        end
        nvec++; if (ka !== 2) begin nerr++; $display("FAIL rmid_tie_a got +%0d exp +2", ka); end
        nvec++; if (kb !== 5) begin nerr++; $display("FAIL rmid_tie_b got +%0d exp +5", kb); end
    endtask

    task automatic test_range();
        logic [31:0] exp_rd;
        exp_rd = RC ? ref_rd[0] : ref_mem[10];
        a_req = 1; a_we = 0; a_addr = 10;
        @(negedge clock);
        nvec++; if (mem_read !== !RC) begin nerr++; $display("FAIL rng_strobe got %b exp %b", mem_read, !RC); end
        @(negedge clock);
        nvec++; if (a_ack !== 1'b1) begin nerr++; $display("FAIL rng_ack got %b exp 1", a_ack); end
        nvec++; if (a_err !== RC) begin nerr++; $display("FAIL rng_err got %b exp %b", a_err, RC); end
        nvec++; if (a_rdata !== exp_rd) begin nerr++; $display("FAIL rng_rdata got %h exp %h", a_rdata, exp_rd); end
        ref_rd[0] = exp_rd;
        a_req = 0;
        @(negedge clock);
    endtask

    // Transaction-level model: grant when the arbiter is free and someone waits,
    // round-robin on ties, strobe one cycle later, ack two cycles later.
    task automatic build_schedule();
        int ip[2];
        int v[2];
        int f, g, w, i, mv, lastp;
        bit ok0, ok1;
        logic [31:0] lrd[2];
        lrd[0] = ref_rd[0]; lrd[1] = ref_rd[1];
        ip[0] = 0; ip[1] = 0;
        v[0] = t0 + r_gap[0][0]; v[1] = t0 + r_gap[1][0];
        f = t0; lastp = 1; nsched = 0;
        while (ip[0] < NT || ip[1] < NT) begin
            mv = 1 << 30;
            if (ip[0] < NT && v[0] < mv) mv = v[0];
            if (ip[1] < NT && v[1] < mv) mv = v[1];
            g = (f > mv) ? f : mv;
            ok0 = (ip[0] < NT) && (v[0] <= g);
            ok1 = (ip[1] < NT) && (v[1] <= g);
            if (ok0 && ok1) w = (lastp == 0) ? 1 : 0;
            else w = ok0 ? 0 : 1;
            i = ip[w];
            s_port[nsched]  = w;
            s_g[nsched]     = g;
            s_we[nsched]    = r_we[w][i];
            s_addr[nsched]  = r_addr[w][i];
            s_wdata[nsched] = r_wdata[w][i];
            s_err[nsched]   = RC && (r_addr[w][i] >= 4'd10);
            if (!s_err[nsched]) begin
                if (r_we[w][i]) ref_mem[r_addr[w][i]] = r_wdata[w][i];
                else lrd[w] = ref_mem[r_addr[w][i]];
            end
            s_rdata[nsched] = lrd[w];
            nsched++;
            lastp = w;
            f = g + 3;
            ip[w]++;
            if (ip[w] < NT) v[w] = g + 2 + r_gap[w][ip[w]];
        end
        ref_rd[0] = lrd[0]; ref_rd[1] = lrd[1];
        tend = s_g[nsched-1] + 3;
    endtask

    task automatic drive_port(input int p);
        int wt;
        bit got;
        for (int i = 0; i < NT; i++) begin
            repeat (r_gap[p][i]) @(negedge clock);
            if (p == 0) begin
                a_we = r_we[p][i]; a_addr = 32'(r_addr[p][i]); a_wdata = r_wdata[p][i]; a_req = 1;
            end else begin
                b_we = r_we[p][i]; b_addr = 32'(r_addr[p][i]); b_wdata = r_wdata[p][i]; b_req = 1;
            end
            wt = 0; got = 0;
            while (!got && wt < 60) begin
                @(negedge clock);
                wt++;
                got = (p == 0) ? a_ack : b_ack;
            end
            if (!got) begin
                nvec++; nerr++;
                $display("FAIL rnd_timeout port %0d txn %0d got no ack exp ack within 60 cycles", p, i);
            end
            if (p == 0) a_req = 0; else b_req = 0;
        end
    endtask

    task automatic check_random();
        int sk, ak;
        bit ew, er, ea, eb;
        for (int c = t0 + 1; c <= tend; c++) begin
            @(negedge clock);
            sk = -1; ak = -1; ew = 0; er = 0; ea = 0; eb = 0;
            for (int j = 0; j < nsched; j++) begin
                if (s_g[j] + 1 == c) sk = j;
                if (s_g[j] + 2 == c) ak = j;
            end
            if (sk >= 0) begin ew = s_we[sk] && !s_err[sk]; er = !s_we[sk] && !s_err[sk]; end
            if (ak >= 0) begin ea = (s_port[ak] == 0); eb = (s_port[ak] == 1); end
            nvec++; if (mem_write !== ew) begin nerr++; $display("FAIL rnd_mem_write cyc %0d got %b exp %b", c, mem_write, ew); end
            nvec++; if (mem_read !== er) begin nerr++; $display("FAIL rnd_mem_read cyc %0d got %b exp %b", c, mem_read, er); end
            nvec++; if (a_ack !== ea) begin nerr++; $display("FAIL rnd_a_ack cyc %0d got %b exp %b", c, a_ack, ea); end
            nvec++; if (b_ack !== eb) begin nerr++; $display("FAIL rnd_b_ack cyc %0d got %b exp %b", c, b_ack, eb); end
            if (ew || er) begin
                nvec++; if (mem_daddress !== 32'(s_addr[sk])) begin nerr++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, mem_daddress, s_addr[sk]); end
            end
            if (ew) begin
                nvec++; if (mem_din !== s_wdata[sk]) begin nerr++; $display("FAIL rnd_din cyc %0d got %h exp %h", c, mem_din, s_wdata[sk]); end
            end
            if (ea) begin
                nvec++; if (a_err !== s_err[ak]) begin nerr++; $display("FAIL rnd_a_err cyc %0d got %b exp %b", c, a_err, s_err[ak]); end
                nvec++; if (a_rdata !== s_rdata[ak]) begin nerr++; $display("FAIL rnd_a_rdata cyc %0d got %h exp %h", c, a_rdata, s_rdata[ak]); end
            end
            if (eb) begin
                nvec++; if (b_err !== s_err[ak]) begin nerr++; $display("FAIL rnd_b_err cyc %0d got %b exp %b", c, b_err, s_err[ak]); end
                nvec++; if (b_rdata !== s_rdata[ak]) begin nerr++; $display("FAIL rnd_b_rdata cyc %0d got %h exp %h", c, b_rdata, s_rdata[ak]); end
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NT; i++) begin
                r_we[p][i]    = $urandom_range(0, 1) == 1;
                r_addr[p][i]  = 4'($urandom_range(0, 11));
                r_wdata[p][i] = $urandom;
                r_gap[p][i]   = $urandom_range(0, 3);
            end
        end
        do_reset();
        @(negedge clock);
        t0 = cyc;
        build_schedule();
        fork
            drive_port(0);
            drive_port(1);
            check_random();
        join
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_back_to_back();
        test_addr_change();
        test_reset_mid();
        test_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the shared data memory (word-addressed, DEPTH words, read/write strobes, registered read data).
Port A is the CPU load/store stage. Port B is the loader/debug requester.
The block serialises requests, drives the memory strobes for exactly one cycle per access, captures read data, and returns a one-cycle ack to the winning requester.

Parameters:
ADDR_W, 32, width of requester and memory addresses
DATA_W, 32, data width
DEPTH, 10, number of implemented memory words; valid addresses are 0..DEPTH-1

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
a_req  input  1  port A request, level, held until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  ADDR_W  port A word address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A transaction complete, one-cycle pulse
a_rdata  output  DATA_W  port A read data, valid with a_ack
a_err  output  1  port A address out of range, valid with a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same as port A, for port B
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_daddress  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_dout  input  DATA_W  memory read data, valid one cycle after the strobe cycle

Behaviour:
- Reset: state=IDLE; all acks, errs, mem_write and mem_read = 0; rdata, mem_daddress and mem_din = 0; priority pointer set so A wins the first tie.
- FSM, three states:
  - IDLE: if no req, stay. Otherwise pick the winner: the single requester, or on a tie the port not granted last. Latch the winner, we, addr and wdata into registers and go to ACCESS.
  - ACCESS: drive mem_daddress and mem_din from the latches. Assert mem_write (we=1) or mem_read (we=0) for exactly this one cycle. Go to RESP.
  - RESP: strobes = 0.
    - For a read, capture mem_dout into the winner's rdata.
    - Pulse the winner's ack for one cycle.
    - Update the pointer to the winner.
    - Go to IDLE.
- Latency: request seen in IDLE at cycle N gives strobe at N+1 and ack at N+2. Back-to-back throughput is one access per 3 cycles.
- The loser's req stays pending; it is granted at the next IDLE. Requests are never dropped.
- req is sampled only in IDLE. A requester that still holds req in the cycle after its ack is treated as issuing a new transaction.
- Requester fields must stay stable while req=1. The arbiter latches them at grant, so later changes do not affect the access in flight.
- rdata holds its value until the next read ack on that port. Write acks leave rdata unchanged.
- Non-winner ack and err are always 0. The two acks are never asserted together.
- Reset mid-transaction: the FSM goes to IDLE next edge, strobes drop, no ack is issued, and the pointer is reset to favour A.

Optional Feature:
Macro DMEM_ARB_RANGE_CHECK_EN.
- Defined: the address is checked at grant. If addr >= DEPTH, ACCESS drives no strobe, RESP pulses ack with err=1, and rdata is unchanged. Timing is identical to a normal access.
- Undefined: no check is made. err is tied to 0 and every access strobes the memory.

Decomposition:
- Shared package dmem_pkg: FSM state encoding (IDLE, ACCESS, RESP), port index constants PORT_A=0 and PORT_B=1, default ADDR_W, DATA_W and DEPTH.
- One natural sub-module, rr_arb2: a two-request round-robin picker with the last-grant pointer. It is combinational pick logic plus the pointer register.

Test Plan:
- A alone writes addr 3 with data 0xDEADBEEF, then reads addr 3 -> mem_write high exactly 1 cycle with mem_daddress=3; read a_ack at +2 cycles with a_rdata=0xDEADBEEF.
- A and B both request from reset, A reading addr 1 and B writing addr 2 -> A granted first, B granted at the next IDLE; acks 3 cycles apart, never overlapping.
- Both req held continuously for 6 transactions -> grant order A,B,A,B,A,B, one ack per 3 cycles.
- B changes b_addr from 4 to 7 during ACCESS -> memory still sees address 4.
- reset asserted during ACCESS of a read -> no ack, strobes 0 the next cycle, and the next tie is granted to A.
- With DMEM_ARB_RANGE_CHECK_EN, A reads addr 10 (DEPTH=10) -> no mem_read, a_ack with a_err=1 at +2, a_rdata unchanged. Without the macro -> mem_read asserted and a_err=0.
